// File: rtl/timeclock_divider_decoder.sv
// timeclock_divider_decoder
// Timing and display front end for the TimeClock FND design.
//   - o_digit_clk: 50 % duty clock with a period of DIGIT_DIV i_clk cycles.
//     It drives the digit-scan counter.
//   - o_time_clk : 50 % duty clock with a period of TIME_DIV i_clk cycles.
//     It is the centisecond tick.
//   - o_font     : active-low 7-segment + DP pattern {dp,g,f,e,d,c,b,a}
//     for the code on i_value.
// Optional build macro: FND_FONT_REG_EN.
//   - When it is defined, o_font is registered. It has one cycle of latency
//     and resets to 8'hFF.
//   - When it is undefined, o_font is a purely combinational function of
//     i_value.
module timeclock_divider_decoder #(
    parameter int DIGIT_DIV = 100_000,
    parameter int TIME_DIV  = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_value,
    output logic       o_digit_clk,
    output logic       o_time_clk,
    output logic [7:0] o_font
);

    // Each divider counts half a period and then flips its output.
    // The width never drops below one bit, so DIV == 2 still has a counter.
    localparam int DIGIT_HALF = DIGIT_DIV / 2;
    localparam int TIME_HALF  = TIME_DIV / 2;
    localparam int DIGIT_W    = (DIGIT_HALF > 1) ? $clog2(DIGIT_HALF) : 1;
    localparam int TIME_W     = (TIME_HALF > 1) ? $clog2(TIME_HALF) : 1;

    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(DIGIT_HALF - 1);
    localparam logic [TIME_W-1:0]  TIME_LAST  = TIME_W'(TIME_HALF - 1);

    logic [DIGIT_W-1:0] r_digit_cnt;
    logic [TIME_W-1:0]  r_time_cnt;
    logic               r_digit_clk;
    logic               r_time_clk;
    logic [7:0]         w_font;

    // Digit-scan divider: at terminal count, wrap the counter and toggle the output.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_digit_cnt <= '0;
            r_digit_clk <= 1'b0;
        end else if (r_digit_cnt == DIGIT_LAST) begin
            r_digit_cnt <= '0;
            r_digit_clk <= ~r_digit_clk;
        end else begin
            r_digit_cnt <= r_digit_cnt + 1'b1;
        end
    end

    // Time-base divider: same scheme as the digit divider, but runs independently.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_time_cnt <= '0;
            r_time_clk <= 1'b0;
        end else if (r_time_cnt == TIME_LAST) begin
            r_time_cnt <= '0;
            r_time_clk <= ~r_time_clk;
        end else begin
            r_time_cnt <= r_time_cnt + 1'b1;
        end
    end

    assign o_digit_clk = r_digit_clk;
    assign o_time_clk  = r_time_clk;

    // Font lookup (active-low, common anode).
    // Codes 11..15 fall into the default branch and are blanked.
    always_comb begin
        w_font = 8'hFF;
        case (i_value)
            4'd0:    w_font = 8'hC0;
            4'd1:    w_font = 8'hF9;
            4'd2:    w_font = 8'hA4;
            4'd3:    w_font = 8'hB0;
            4'd4:    w_font = 8'h99;
            4'd5:    w_font = 8'h92;
            4'd6:    w_font = 8'h82;
            4'd7:    w_font = 8'hF8;
            4'd8:    w_font = 8'h80;
            4'd9:    w_font = 8'h90;
            4'd10:   w_font = 8'h7F;
            default: w_font = 8'hFF;
        endcase
    end

`ifdef FND_FONT_REG_EN
    logic [7:0] r_font;

    // Registered font output: blank while in reset, one cycle behind i_value.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_font <= 8'hFF;
        end else begin
            r_font <= w_font;
        end
    end

    assign o_font = r_font;
`else
    assign o_font = w_font;
`endif

endmodule

// File: tb/tb_timeclock_divider_decoder.sv
// Testbench for timeclock_divider_decoder.
// It uses small divide ratios: DIGIT_DIV=4 and TIME_DIV=10.
// A reference model predicts each output:
//   - Each divider output is (edges since reset / half period) mod 2.
//   - The font comes from a lookup table.
// Runs directed steps first, then randomised values and resets.
module tb_timeclock_divider_decoder;

    localparam int D_DIV = 4;
    localparam int T_DIV = 10;

    logic       clk = 1'b0;
    logic       i_reset = 1'b0;
    logic [3:0] i_value = 4'd0;
    logic       o_digit_clk;
    logic       o_time_clk;
    logic [7:0] o_font;

    int checks = 0;
    int errors = 0;

    // Model state
    int         n_edges = 0;        // i_clk rising edges since last reset release
    logic [7:0] exp_font_reg = 8'hFF;
    logic [7:0] font_lut [16];

    timeclock_divider_decoder #(
        .DIGIT_DIV(D_DIV),
        .TIME_DIV (T_DIV)
    ) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_value    (i_value),
        .o_digit_clk(o_digit_clk),
        .o_time_clk (o_time_clk),
        .o_font     (o_font)
    );

    always #5 clk = ~clk;

    function automatic logic div_model(input int edges, input int div);
        return logic'((edges / (div / 2)) % 2);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string phase, input logic [3:0] v);
        check({phase, " digit_clk"}, {7'd0, o_digit_clk}, {7'd0, div_model(n_edges, D_DIV)});
        check({phase, " time_clk"},  {7'd0, o_time_clk},  {7'd0, div_model(n_edges, T_DIV)});
`ifdef FND_FONT_REG_EN
        check({phase, " font"}, o_font, exp_font_reg);
`else
        check({phase, " font"}, o_font, font_lut[v]);
`endif
    endtask

    // One i_clk cycle.
    // Inputs change at the falling edge, where the checks exercise the
    // immediate reset and the combinational font.
    // The outputs are then checked again just after the rising edge.
    task automatic cycle(input logic [3:0] v, input logic rst);
        @(negedge clk);
        i_value = v;
        i_reset = rst;
        if (rst) begin
            n_edges = 0;
            exp_font_reg = 8'hFF;
        end
        #1;
        check_all("neg", v);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_font_reg = 8'hFF;
        end else begin
            n_edges++;
            exp_font_reg = font_lut[v];
        end
        check_all("pos", v);
    endtask

    initial begin
        font_lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                     8'h80, 8'h90, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        #1 i_reset = 1'b1;

        // Hold reset for 50 cycles: the dividers must stay low.
        for (int i = 0; i < 50; i++) cycle(4'($urandom_range(0, 15)), 1'b1);
        $display("reset hold: 50 cycles done");

        // Release reset and sweep every code: checks the font and the first divider edges.
        for (int v = 0; v < 16; v++) begin
            cycle(4'(v), 1'b0);
            $display("sweep value=%0d font=%h", v, o_font);
        end

        // Reset during the high phase of o_time_clk.
        cycle(4'd0, 1'b1);
        for (int i = 0; i < 7; i++) cycle(4'd3, 1'b0);
        check("time_clk high before reset", {7'd0, o_time_clk}, 8'd1);
        cycle(4'd8, 1'b1);
        // The next rise must come exactly TIME_DIV/2 edges after release.
        for (int i = 0; i < T_DIV / 2; i++) cycle(4'd8, 1'b0);
        check("time_clk rise after restart", {7'd0, o_time_clk}, 8'd1);
        $display("mid-period reset: restart checked");

        // Randomised values with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0));
        end
        $display("random phase: 600 cycles done");

        // Long run without reset: count output edges and compare with the ratio.
        begin
            int d_rises = 0;
            int t_rises = 0;
            logic pd;
            logic pt;
            cycle(4'd0, 1'b1);
            pd = o_digit_clk;
            pt = o_time_clk;
            for (int i = 0; i < 200; i++) begin
                cycle(4'($urandom_range(0, 15)), 1'b0);
                if (o_digit_clk && !pd) d_rises++;
                if (o_time_clk && !pt) t_rises++;
                pd = o_digit_clk;
                pt = o_time_clk;
            end
            check("digit rises in 200", 8'(d_rises), 8'(200 / D_DIV));
            check("time rises in 200",  8'(t_rises), 8'(200 / T_DIV));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
